// File: rtl/down_counter_timer_pkg.sv
// Shared types for the down-counter timer: FSM state encoding and default width.
package down_counter_timer_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle between the CNN controller (master) and the down-counter timer (slave).
interface down_counter_timer_if
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             done;
  logic             tc_pulse;

  modport master (
    output clear, load, load_value, enable, auto_reload,
    input  count_out, busy, done, tc_pulse
  );

  modport slave (
    input  clear, load, load_value, enable, auto_reload,
    output count_out, busy, done, tc_pulse
  );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable, pausable down-counter with sticky done, one-cycle terminal pulse and optional auto-reload.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  down_counter_timer_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (bus.load) begin
      state_d  = ST_RUN;
      count_d  = bus.load_value;
      reload_d = bus.load_value;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.enable) begin
            if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // Terminal: the zero count is held for one enabled cycle before firing.
              tc_d = 1'b1;
              if (bus.auto_reload) begin
                count_d = reload_q;
              end else begin
                state_d = ST_DONE;
                count_d = '0;
              end
            end
          end
        end
        ST_DONE, ST_IDLE: count_d = '0;
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
    // Status flags track the next state so they update on the same edge as the FSM.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tc_pulse  = tc_q;

endmodule
